// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner codes
// and the latency counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        DONE
    } state_t;

    typedef logic owner_t;

    localparam owner_t OWN_CPU = 1'b0;
    localparam owner_t OWN_DBG = 1'b1;

    // Enough bits to hold the latency value itself.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the memory.
// slave: arbiter side; master: requesters and memory side.
interface mem_arb_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_ld;
    logic             cpu_st;
    logic [WIDTH-1:0] cpu_rdata;
    logic             cpu_mdelay;

    logic             dbg_req;
    logic             dbg_we;
    logic [WIDTH-1:0] dbg_addr;
    logic [WIDTH-1:0] dbg_wdata;
    logic             dbg_ack;
    logic [WIDTH-1:0] dbg_rdata;

    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ld;
    logic             mem_st;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_ld, cpu_st,
        output cpu_rdata, cpu_mdelay,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_addr, mem_wdata, mem_ld, mem_st,
        input  mem_rdata
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_ld, cpu_st,
        input  cpu_rdata, cpu_mdelay,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_addr, mem_wdata, mem_ld, mem_st,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_pick.sv
// 2-way grant picker. MEM_ARB_ROUND_ROBIN_EN selects round-robin ties;
// otherwise the loader always wins a tie.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  owner_t last_owner,
    output owner_t winner
);

    owner_t tie;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign tie = (last_owner == OWN_DBG) ? OWN_CPU : OWN_DBG;
`else
    logic unused_last;
    assign unused_last = last_owner;
    assign tie = OWN_DBG;
`endif

    // Lone requester wins outright; a tie is resolved by the mode above.
    always_comb begin
        winner = OWN_DBG;
        if (cpu_req && dbg_req) begin
            winner = tie;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported data memory between the core and the loader.
// Build option: MEM_ARB_ROUND_ROBIN_EN (round-robin ties, else loader wins).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 1
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    localparam int CW = cnt_width(MEM_LAT);

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    owner_t           winner;
    logic             we;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             ld_strobe;
    logic             st_strobe;
    logic             ack;
    logic [WIDTH-1:0] rdata_reg;
    logic             cpu_req;

    assign cpu_req = bus.cpu_ld | bus.cpu_st;

    mem_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dbg_req    (bus.dbg_req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Sequencer: arbitrate, strobe memory once, wait out latency, respond.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_owner <= OWN_DBG;
            we         <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            wdata      <= '0;
            ld_strobe  <= 1'b0;
            st_strobe  <= 1'b0;
            ack        <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            ld_strobe <= 1'b0;
            st_strobe <= 1'b0;
            ack       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req || bus.dbg_req) begin
                        owner      <= winner;
                        last_owner <= winner;
                        state      <= ACCESS;
                        if (winner == OWN_CPU) begin
                            addr      <= bus.cpu_addr;
                            wdata     <= bus.cpu_wdata;
                            we        <= bus.cpu_st;
                            st_strobe <= bus.cpu_st;
                            ld_strobe <= ~bus.cpu_st;
                        end else begin
                            addr      <= bus.dbg_addr;
                            wdata     <= bus.dbg_wdata;
                            we        <= bus.dbg_we;
                            st_strobe <= bus.dbg_we;
                            ld_strobe <= ~bus.dbg_we;
                        end
                    end
                end
                ACCESS: begin
                    if (we) begin
                        state <= DONE;
                        ack   <= (owner == OWN_DBG);
                    end else begin
                        cnt   <= CW'(MEM_LAT);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        rdata_reg <= bus.mem_rdata;
                        ack       <= (owner == OWN_DBG);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.mem_ld    = ld_strobe;
    assign bus.mem_st    = st_strobe;
    assign bus.dbg_ack   = ack;
    assign bus.dbg_rdata = rdata_reg;
    assign bus.cpu_rdata = rdata_reg;

    // Combinational stall so the very first request cycle already holds the core.
    assign bus.cpu_mdelay = ~rst & cpu_req
                          & ~((state == DONE) && (owner == OWN_CPU));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with MEM_LAT=1 and MEM_LAT=3 instances.
// Tie expectations follow MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expd;
    } op_t;

    typedef struct {
        owner_t      own;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arb_if #(.WIDTH(32)) bus ();
    mem_arb_if #(.WIDTH(32)) bus3 ();

    mem_arbiter #(.WIDTH(32), .MEM_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_arbiter #(.WIDTH(32), .MEM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int checks = 0;
    int failures = 0;
    int ld_cnt = 0;
    int ack_cnt = 0;
    int tc_g;
    int td_g;
    exp_t sb[$];
    op_t  cq[$];
    op_t  dq[$];

    logic [31:0] mem [256];
    logic [31:0] rd1;
    logic [31:0] p3 [3];

    // Memory model: writes on strobe, read data valid exactly MEM_LAT cycles later.
    always @(posedge clk) begin
        if (bus.mem_st) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        rd1   <= bus.mem_ld ? mem[bus.mem_addr[7:0]] : 32'hxxxxxxxx;
        p3[0] <= bus3.mem_ld ? mem[bus3.mem_addr[7:0]] : 32'hxxxxxxxx;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus.mem_rdata  = rd1;
    assign bus3.mem_rdata = p3[2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input owner_t own, input logic [31:0] data);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk("sb_owner", own, e.own);
            if (e.rd) chk(own == OWN_CPU ? "sb_cpu_data" : "sb_dbg_data", data, e.data);
        end
    endtask

    // Response monitor: every completed transfer is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_ld) ld_cnt++;
            if (bus.dbg_ack) begin
                ack_cnt++;
                sb_pop(OWN_DBG, bus.dbg_rdata);
            end
            if ((bus.cpu_ld || bus.cpu_st) && !bus.cpu_mdelay)
                sb_pop(OWN_CPU, bus.cpu_rdata);
        end
    end

    function automatic op_t mk(input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] ex);
        op_t o;
        o.we = we; o.addr = a; o.wdata = wd; o.expd = ex;
        return o;
    endfunction

    task automatic drive_cpu(input int i);
        if (i < cq.size()) begin
            bus.cpu_ld    = ~cq[i].we;
            bus.cpu_st    = cq[i].we;
            bus.cpu_addr  = cq[i].addr;
            bus.cpu_wdata = cq[i].wdata;
        end else begin
            bus.cpu_ld = 1'b0;
            bus.cpu_st = 1'b0;
        end
    endtask

    task automatic drive_dbg(input int i);
        if (i < dq.size()) begin
            bus.dbg_req   = 1'b1;
            bus.dbg_we    = dq[i].we;
            bus.dbg_addr  = dq[i].addr;
            bus.dbg_wdata = dq[i].wdata;
        end else begin
            bus.dbg_req = 1'b0;
        end
    endtask

    task automatic push_plan(input logic [15:0] eo, input int en);
        int ci = 0;
        int di = 0;
        exp_t e;
        for (int i = 0; i < en; i++) begin
            e.own = eo[i];
            if (eo[i] == OWN_CPU) begin
                e.rd = ~cq[ci].we; e.data = cq[ci].expd; ci++;
            end else begin
                e.rd = ~dq[di].we; e.data = dq[di].expd; di++;
            end
            sb.push_back(e);
        end
    endtask

    // Drives the cq/dq scripts, advancing each requester on its completion.
    task automatic go(input logic [15:0] eo, input int en, input int budget);
        int ci = 0;
        int di = 0;
        int n = 0;
        logic [15:0] order = '0;
        logic cd;
        logic dd;
        tc_g = -1;
        td_g = -1;
        push_plan(eo, en);
        drive_cpu(0);
        drive_dbg(0);
        for (int t = 0; t < budget; t++) begin
            if (ci >= cq.size() && di >= dq.size()) break;
            @(negedge clk);
            cd = (bus.cpu_ld || bus.cpu_st) && !bus.cpu_mdelay;
            dd = bus.dbg_ack && (di < dq.size());
            if (cd) begin tc_g = t; order[n] = OWN_CPU; n++; ci++; end
            if (dd) begin td_g = t; order[n] = OWN_DBG; n++; di++; end
            @(posedge clk); #1;
            if (cd) drive_cpu(ci);
            if (dd) drive_dbg(di);
        end
        drive_cpu(cq.size());
        drive_dbg(dq.size());
        chk("run_done", n, en);
        chk("grant_order", order, eo);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cpu_ld = 1'b0; bus.cpu_st = 1'b0; bus.dbg_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int a0;
        int tack;
        int t3;
        bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_st = 1'b0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0;
        bus.dbg_addr = '0; bus.dbg_wdata = '0;
        bus3.cpu_addr = '0; bus3.cpu_wdata = '0;
        bus3.cpu_ld = 1'b0; bus3.cpu_st = 1'b0;
        bus3.dbg_req = 1'b0; bus3.dbg_we = 1'b0;
        bus3.dbg_addr = '0; bus3.dbg_wdata = '0;
        bus.cpu_ld = 1'b1;
        bus.cpu_addr = 32'h10;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mdelay", bus.cpu_mdelay, 0);
        chk("rst_mem_ld", bus.mem_ld, 0);
        chk("rst_mem_st", bus.mem_st, 0);
        chk("rst_dbg_ack", bus.dbg_ack, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 0);
        bus.cpu_ld = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        cq = {};
        dq = {mk(1'b1, 32'h10, 32'hDEADBEEF, 32'h0)};
        go(16'h1, 1, 10);
        chk("dbg_wr_ack_lat", td_g, 2);

        cq = {mk(1'b0, 32'h10, 32'h0, 32'hDEADBEEF)};
        dq = {};
        a0 = ld_cnt;
        go(16'h0, 1, 12);
        chk("cpu_rd_stall", tc_g, 3);
        chk("cpu_rd_ld_pulses", ld_cnt - a0, 1);

        cq = {};
        dq = {mk(1'b1, 32'h0, 32'h13, 32'h0)};
        go(16'h1, 1, 10);
        chk("dbg_wr2_ack_lat", td_g, 2);
        cq = {mk(1'b0, 32'h0, 32'h0, 32'h13)};
        dq = {};
        go(16'h0, 1, 12);
        chk("cpu_rd2_stall", tc_g, 3);

        do_reset();
        cq = {mk(1'b0, 32'h10, 32'h0, 32'hDEADBEEF)};
        dq = {mk(1'b0, 32'h0, 32'h0, 32'h13)};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        go(16'b10, 2, 20);
        chk("tie_cpu_done", tc_g, 3);
        chk("tie_dbg_done", td_g, 7);
`else
        go(16'b01, 2, 20);
        chk("tie_cpu_done", tc_g, 7);
        chk("tie_dbg_done", td_g, 3);
`endif

        do_reset();
        cq = {mk(1'b0, 32'h10, 32'h0, 32'hDEADBEEF),
              mk(1'b0, 32'h0, 32'h0, 32'h13)};
        dq = {};
        for (int i = 0; i < 4; i++)
            dq.push_back(mk(1'b1, 32'h20 + i, 32'hA0 + i, 32'h0));
`ifdef MEM_ARB_ROUND_ROBIN_EN
        go(16'b111010, 6, 60);
`else
        go(16'b001111, 6, 60);
`endif
        cq = {};
        dq = {mk(1'b0, 32'h22, 32'h0, 32'hA2)};
        go(16'h1, 1, 10);
        chk("dbg_rd_ack_lat", td_g, 3);

        sb.push_back('{OWN_DBG, 1'b1, 32'hA3});
        a0 = ack_cnt;
        tack = -1;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h23;
        @(posedge clk); #1 bus.dbg_req = 1'b0;
        for (int t = 1; t < 12; t++) begin
            @(negedge clk);
            if (bus.dbg_ack) begin tack = t; break; end
        end
        chk("drop_ack_lat", tack, 3);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_ack_once", ack_cnt - a0, 1);

        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h20;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        bus.cpu_ld = 1'b1; bus.cpu_addr = 32'h10;
        @(negedge clk);
        chk("rstwait_mdelay_in_rst", bus.cpu_mdelay, 0);
        a0 = ack_cnt;
        @(posedge clk); #1;
        rst = 1'b0; bus.cpu_ld = 1'b0; bus.dbg_req = 1'b0;
        @(negedge clk);
        chk("rstwait_mem_ld", bus.mem_ld, 0);
        chk("rstwait_mem_st", bus.mem_st, 0);
        chk("rstwait_dbg_ack", bus.dbg_ack, 0);
        chk("rstwait_mdelay", bus.cpu_mdelay, 0);
        repeat (4) @(negedge clk);
        chk("rstwait_no_ack", ack_cnt - a0, 0);
        @(posedge clk); #1;
        cq = {mk(1'b0, 32'h20, 32'h0, 32'hA0)};
        dq = {};
        go(16'h0, 1, 12);
        chk("post_rst_stall", tc_g, 3);

        t3 = -1;
        bus3.cpu_ld = 1'b1; bus3.cpu_addr = 32'h10;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!bus3.cpu_mdelay) begin t3 = t; break; end
        end
        chk("lat3_done", t3, 5);
        chk("lat3_data", bus3.cpu_rdata, 32'hDEADBEEF);
        @(posedge clk); #1 bus3.cpu_ld = 1'b0;

        repeat (2) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
